fetch_sequencer: RTL

- Instruction-fetch control stage directly upstream of program_counter. Reads the current PC (`count`), fetches the instruction word from instruction memory over a req/ack handshake, and latches it into an instruction register.
- Resolves JMP/BEQ/HALT locally and issues all other instructions to decode/ALU over a valid/ready handshake.
- Drives program_counter's LoadPC, IncPC and new_count so the PC advances exactly once per instruction.

---
 rtl/fseq_pkg.sv | 42 ++++
 rtl/fseq_opdecode.sv | 34 +++
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fseq_pkg
//  Purpose : Shared opcodes, instruction field positions and FSM state
//            encoding for the fetch sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package fseq_pkg;

    localparam int c_OPC_W   = 4;
    localparam int c_TGT_MSB = 7;
    localparam int c_TGT_LSB = 0;

    localparam logic [c_OPC_W-1:0] c_OP_ADD  = 4'b0001;
    localparam logic [c_OPC_W-1:0] c_OP_SUB  = 4'b0010;
    localparam logic [c_OPC_W-1:0] c_OP_NOR  = 4'b0011;
    localparam logic [c_OPC_W-1:0] c_OP_SHFL = 4'b1011;
    localparam logic [c_OPC_W-1:0] c_OP_SHFR = 4'b1100;
    localparam logic [c_OPC_W-1:0] c_OP_JMP  = 4'b1000;
    localparam logic [c_OPC_W-1:0] c_OP_BEQ  = 4'b1001;
    localparam logic [c_OPC_W-1:0] c_OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_UPDATE = 3'd4,
        S_HALTED = 3'd5
    } fseq_state_t;

    // The opcode always occupies the top nibble, whatever the word width.
    function automatic int opc_msb(input int instr_w);
        return instr_w - 1;
    endfunction

    function automatic int opc_lsb(input int instr_w);
        return instr_w - c_OPC_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fseq_opdecode.sv
`default_nettype none
// ============================================================================
//  Module  : fseq_opdecode
//  Purpose : Combinational opcode classifier: control-flow vs. ALU work.
//  Rev     : 1.0  initial release
// ============================================================================
module fseq_opdecode
    import fseq_pkg::*;
(
    input  logic [c_OPC_W-1:0] i_opcode,
    output logic               is_jmp,
    output logic               is_beq,
    output logic               is_halt,
    output logic               is_alu
);

    always_comb begin
        is_jmp  = 1'b0;
        is_beq  = 1'b0;
        is_halt = 1'b0;
        is_alu  = 1'b0;
        case (i_opcode)
            c_OP_JMP:  is_jmp  = 1'b1;
            c_OP_BEQ:  is_beq  = 1'b1;
            c_OP_HALT: is_halt = 1'b1;
            c_OP_ADD, c_OP_SUB, c_OP_NOR, c_OP_SHFL, c_OP_SHFR:
                       is_alu  = 1'b1;
            // Unlisted opcodes are handed downstream like ALU work.
            default:   is_alu  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_sequencer
//  Purpose : Fetches, resolves JMP/BEQ/HALT locally, issues the rest, and
//            steps program_counter exactly once per instruction.
//  Option  : FSEQ_TIMEOUT_EN enables the fetch watchdog and fault output.
//  Rev     : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fseq_pkg::*;
#(
    parameter int INSTR_W        = 16,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc_count,
    output logic               LoadPC,
    output logic               IncPC,
    output logic [ADDR_W-1:0]  new_count,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               zero_flag,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               halted,
    output logic               fault
);

    localparam int c_OPC_MSB = opc_msb(INSTR_W);
    localparam int c_OPC_LSB = opc_lsb(INSTR_W);

    fseq_state_t        r_state;
    fseq_state_t        w_next;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_ir_pc;
    logic [ADDR_W-1:0]  r_new_count;
    logic               r_load_sel;
    logic               w_timeout;
    logic               w_is_jmp;
    logic               w_is_beq;
    logic               w_is_halt;
    logic               w_is_alu;
    logic               w_take_load;
    logic [ADDR_W-1:0]  w_target;

    fseq_opdecode u_opdecode (
        .i_opcode (r_ir[c_OPC_MSB:c_OPC_LSB]),
        .is_jmp   (w_is_jmp),
        .is_beq   (w_is_beq),
        .is_halt  (w_is_halt),
        .is_alu   (w_is_alu)
    );

    assign w_target    = ADDR_W'(r_ir[c_TGT_MSB:c_TGT_LSB]);
    assign w_take_load = w_is_jmp || (w_is_beq && zero_flag);

`ifdef FSEQ_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_fault;

    // Fires on the last allowed FETCH cycle that still has no ack.
    assign w_timeout = (r_state == S_FETCH) && !imem_ack
                       && (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            if ((r_state == S_FETCH) && !imem_ack) begin
                r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault = r_fault;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
    assign fault     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALTED;
                end
            end
            S_DECODE: begin
                if (w_is_alu) begin
                    w_next = S_ISSUE;
                end else if (w_is_halt) begin
                    w_next = S_HALTED;
                end else begin
                    w_next = S_UPDATE;
                end
            end
            S_ISSUE: begin
                if (ir_ready) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: w_next = S_FETCH;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    // Instruction register and PC-update selection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_new_count <= '0;
            r_load_sel  <= 1'b0;
        end else begin
            if ((r_state == S_FETCH) && imem_ack) begin
                r_ir    <= imem_rdata;
                r_ir_pc <= pc_count;
            end
            if (r_state == S_DECODE) begin
                r_load_sel <= w_take_load;
                if (w_take_load) begin
                    r_new_count <= w_target;
                end
            end
        end
    end

    // Outputs decoded from state so they collapse as soon as reset asserts.
    always_comb begin
        imem_req  = (r_state == S_FETCH);
        imem_addr = (r_state == S_FETCH) ? pc_count : '0;
        ir_valid  = (r_state == S_ISSUE);
        LoadPC    = (r_state == S_UPDATE) && r_load_sel;
        IncPC     = (r_state == S_UPDATE) && !r_load_sel;
        halted    = (r_state == S_HALTED);
        ir_out    = r_ir;
        ir_pc     = r_ir_pc;
        new_count = r_new_count;
    end

endmodule
`default_nettype wire
